reg_bus_arbiter: RTL and testbench
==================================

REG_BUS_ARBITER -- requirements
Module: reg_bus_arbiter

Interface
REQ-001 The block SHALL have parameter N_REQ, default 3, number of requesters sharing the register-file bus (2..4).
REQ-002 The block SHALL have parameter AW, default 19, bus address width.
REQ-003 The block SHALL have parameter DW, default 19, bus data width.
REQ-004 The block SHALL have port clk  input  1  clock; all logic rising-edge.
REQ-005 The block SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 The block SHALL have port req_valid  input  N_REQ  per-requester command pending.
REQ-007 The block SHALL have port req_write  input  N_REQ  per-requester 1=write, 0=read.
REQ-008 The block SHALL have port req_lock  input  N_REQ  per-requester hold-grant request.
REQ-009 The block SHALL have port req_addr  input  N_REQ*AW  packed addresses, requester i at [i*AW +: AW].
REQ-010 The block SHALL have port req_wdata  input  N_REQ*DW  packed write data, same packing.
REQ-011 The block SHALL have port req_ready  output  N_REQ  one-cycle command-accept pulse.
REQ-012 The block SHALL have port rsp_valid  output  N_REQ  one-cycle completion pulse.
REQ-013 The block SHALL have port rsp_rdata  output  DW  read data, shared by all requesters, qualified by rsp_valid.
REQ-014 The block SHALL have port bus_valid  output  1  register-file access strobe.
REQ-015 The block SHALL have port bus_write  output  1  register-file write enable.
REQ-016 The block SHALL have port bus_addr  output  AW  register-file address.
REQ-017 The block SHALL have port bus_wdata  output  DW  register-file write data.
REQ-018 The block SHALL have port bus_rdata  input  DW  combinational register-file read data.

Function
REQ-019 The FSM SHALL have states IDLE, ISSUE, RESP; transitions IDLE->ISSUE on acceptance, ISSUE->RESP always, RESP->IDLE always.
REQ-020 In IDLE with any req_valid set, the block SHALL pick one winner, pulse req_ready[winner], and latch its write/addr/wdata and winner index in the same cycle.
REQ-021 Winner selection SHALL be round-robin: search starts at index (last_grant+1) mod N_REQ and takes the first set req_valid.
REQ-022 last_grant SHALL update to the winner on every acceptance, except under REQ-033.
REQ-023 In ISSUE, bus_valid SHALL be 1 for exactly one cycle, driven from the latched command; bus_rdata SHALL be sampled at the end of that cycle.
REQ-024 In RESP, rsp_valid[winner] SHALL be 1 for one cycle; rsp_rdata SHALL be the sampled read data for reads and 0 for writes.
REQ-025 Outside ISSUE, bus_valid, bus_write, bus_addr and bus_wdata SHALL be 0.
REQ-026 Latency SHALL be 2 cycles from req_ready to rsp_valid; peak throughput SHALL be one transaction per 3 cycles.
REQ-027 A requester SHALL hold req_valid and its command stable until it sees req_ready; the block SHALL ignore any change in other cycles.
REQ-028 req_valid deasserted before acceptance SHALL withdraw the request without side effects.
REQ-029 At most one bit of req_ready and at most one bit of rsp_valid SHALL be set in any cycle.
REQ-030 rsp_rdata SHALL hold its value until the next RESP.

Reset
REQ-031 While rst_n is low, state SHALL be IDLE, all outputs 0, and last_grant SHALL be N_REQ-1, so requester 0 has first priority.
REQ-032 Reset asserted in ISSUE or RESP SHALL abort the transaction with no rsp_valid; a write already presented on the bus in ISSUE is not retracted.

Configuration
REQ-033 With REGARB_LOCK_EN defined, if req_lock[winner] is 1 at acceptance, the next IDLE arbitration SHALL grant that requester again if its req_valid is 1, without advancing last_grant; otherwise normal round-robin applies.
REQ-034 Without REGARB_LOCK_EN, req_lock SHALL be ignored and no lock state is implemented.

Verification
REQ-035 After reset, req_valid=3'b111 held continuously -> grants in order 0,1,2,0.
REQ-036 Requester 1 writes addr 0x00004, data 0x12345, then reads addr 0x00004 -> second rsp_valid[1] returns rsp_rdata=0x12345; the write's rsp_rdata is 0.
REQ-037 Single read by requester 2 accepted at cycle T -> bus_valid=1 at T+1 only, rsp_valid[2]=1 at T+2 only.
REQ-038 With REGARB_LOCK_EN, requester 0 holds req_lock=1 and valid while req_valid=3'b111 -> four consecutive grants to 0; after lock drops -> 1 then 2.
REQ-039 rst_n pulled low during ISSUE -> no rsp_valid; after release, pending req_valid=3'b100 -> requester 2 granted, since the pointer has been reset.
REQ-040 req_valid[1] pulsed for one cycle while requester 0 is being serviced -> requester 1 is never granted and no spurious rsp_valid occurs.

Source files
------------

// File: rtl/reg_bus_arbiter_if.sv
// Requester and register-file signals of reg_bus_arbiter, grouped for port use.
// slave = arbiter side, master = requesters plus register-file model side.
interface reg_bus_arbiter_if #(
    parameter int N_REQ = 3,
    parameter int AW    = 19,
    parameter int DW    = 19
) ();
    logic [N_REQ-1:0]    req_valid;
    logic [N_REQ-1:0]    req_write;
    logic [N_REQ-1:0]    req_lock;
    logic [N_REQ*AW-1:0] req_addr;
    logic [N_REQ*DW-1:0] req_wdata;
    logic [N_REQ-1:0]    req_ready;
    logic [N_REQ-1:0]    rsp_valid;
    logic [DW-1:0]       rsp_rdata;
    logic                bus_valid;
    logic                bus_write;
    logic [AW-1:0]       bus_addr;
    logic [DW-1:0]       bus_wdata;
    logic [DW-1:0]       bus_rdata;

    modport slave (
        input  req_valid, req_write, req_lock, req_addr, req_wdata, bus_rdata,
        output req_ready, rsp_valid, rsp_rdata, bus_valid, bus_write, bus_addr, bus_wdata
    );

    modport master (
        output req_valid, req_write, req_lock, req_addr, req_wdata, bus_rdata,
        input  req_ready, rsp_valid, rsp_rdata, bus_valid, bus_write, bus_addr, bus_wdata
    );
endinterface

// File: rtl/reg_bus_arbiter.sv
// Round-robin arbiter sharing one register-file bus among N_REQ requesters (IDLE/ISSUE/RESP).
// Optional grant locking is compiled in with the REGARB_LOCK_EN macro.
module reg_bus_arbiter #(
    parameter int N_REQ = 3,
    parameter int AW    = 19,
    parameter int DW    = 19
) (
    input  logic               clk,
    input  logic               rst_n,
    reg_bus_arbiter_if.slave   rb
);
    localparam int IW = $clog2(N_REQ);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_RESP  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [IW-1:0]    r_last_grant;
    logic [IW-1:0]    r_winner;
    logic [IW-1:0]    w_rr_idx;
    logic [IW-1:0]    w_probe;
    logic [IW-1:0]    w_winner;
    logic             w_rr_found;
    logic             w_advance;
    logic             w_accept;
    logic [N_REQ-1:0] w_ready;
    logic [N_REQ-1:0] r_rsp_valid;
    logic [DW-1:0]    r_rsp_rdata;
    logic             r_bus_valid;
    logic             r_bus_write;
    logic [AW-1:0]    r_bus_addr;
    logic [DW-1:0]    r_bus_wdata;

    // Round-robin search starting one past the last grant
    always_comb begin
        w_rr_found = 1'b0;
        w_rr_idx   = r_last_grant;
        w_probe    = r_last_grant;
        for (int k = 1; k <= N_REQ; k++) begin
            w_probe = IW'((int'(r_last_grant) + k) % N_REQ);
            if (!w_rr_found && rb.req_valid[w_probe]) begin
                w_rr_found = 1'b1;
                w_rr_idx   = w_probe;
            end else begin
                w_rr_found = w_rr_found;
            end
        end
    end

`ifdef REGARB_LOCK_EN
    logic          r_lock_active;
    logic [IW-1:0] r_lock_idx;

    // A held lock re-grants its owner without moving the round-robin pointer
    always_comb begin
        if (r_lock_active && rb.req_valid[r_lock_idx]) begin
            w_winner  = r_lock_idx;
            w_advance = 1'b0;
        end else begin
            w_winner  = w_rr_idx;
            w_advance = 1'b1;
        end
    end

    // Lock ownership is re-evaluated at every acceptance
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lock_active <= 1'b0;
            r_lock_idx    <= '0;
        end else if (w_accept) begin
            r_lock_active <= rb.req_lock[w_winner];
            r_lock_idx    <= w_winner;
        end
    end
`else
    logic w_unused_lock;
    assign w_unused_lock = |rb.req_lock;
    assign w_winner      = w_rr_idx;
    assign w_advance     = 1'b1;
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and accept pulse; no acceptance while reset is held
    always_comb begin
        w_state_nxt = r_state;
        w_ready     = '0;
        w_accept    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (rst_n && (|rb.req_valid)) begin
                    w_accept          = 1'b1;
                    w_ready[w_winner] = 1'b1;
                    w_state_nxt       = S_ISSUE;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_ISSUE: w_state_nxt = S_RESP;
            S_RESP:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Command latch drives the bus for the single ISSUE cycle; response built from it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_grant <= IW'(N_REQ - 1);
            r_winner     <= '0;
            r_bus_valid  <= 1'b0;
            r_bus_write  <= 1'b0;
            r_bus_addr   <= '0;
            r_bus_wdata  <= '0;
            r_rsp_valid  <= '0;
            r_rsp_rdata  <= '0;
        end else begin
            r_bus_valid <= w_accept;
            r_bus_write <= w_accept ? rb.req_write[w_winner] : 1'b0;
            r_bus_addr  <= w_accept ? rb.req_addr[int'(w_winner) * AW +: AW] : '0;
            r_bus_wdata <= w_accept ? rb.req_wdata[int'(w_winner) * DW +: DW] : '0;
            if (w_accept) begin
                r_winner <= w_winner;
            end
            if (w_accept && w_advance) begin
                r_last_grant <= w_winner;
            end
            r_rsp_valid <= '0;
            if (r_state == S_ISSUE) begin
                r_rsp_valid[r_winner] <= 1'b1;
                r_rsp_rdata           <= r_bus_write ? '0 : rb.bus_rdata;
            end
        end
    end

    assign rb.req_ready = w_ready;
    assign rb.rsp_valid = r_rsp_valid;
    assign rb.rsp_rdata = r_rsp_rdata;
    assign rb.bus_valid = r_bus_valid;
    assign rb.bus_write = r_bus_write;
    assign rb.bus_addr  = r_bus_addr;
    assign rb.bus_wdata = r_bus_wdata;
endmodule

// File: tb/tb_reg_bus_arbiter.sv
// Scoreboard bench for reg_bus_arbiter: per-requester command queues, expected grant order,
// in-flight transaction tracking and a small register-file model.
module tb_reg_bus_arbiter;
    localparam int N_REQ = 3;
    localparam int AW    = 19;
    localparam int DW    = 19;

    typedef struct packed {
        logic [1:0]    idx;
        logic          wr;
        logic          lk;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] rdata;
    } txn_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    reg_bus_arbiter_if #(.N_REQ(N_REQ), .AW(AW), .DW(DW)) rb ();

    reg_bus_arbiter #(.N_REQ(N_REQ), .AW(AW), .DW(DW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .rb    (rb)
    );

    txn_t          cmd_q [N_REQ][$];
    txn_t          grant_q [$];
    txn_t          infl_q [$];
    logic [DW-1:0] mem [16];
    bit   [15:0]   wr_mask;
    int            checks   = 0;
    int            failures = 0;

    function automatic logic [DW-1:0] init_val(input logic [3:0] a);
        return 19'h0A000 + {15'd0, a};
    endfunction

    function automatic txn_t mk(input int i, input logic w, input logic l, input int a,
                                input logic [DW-1:0] d, input logic [DW-1:0] r);
        txn_t t;
        t.idx   = 2'(i);
        t.wr    = w;
        t.lk    = l;
        t.addr  = AW'(a);
        t.wdata = d;
        t.rdata = r;
        return t;
    endfunction

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Register-file model: combinational read, write on the bus strobe
    assign rb.bus_rdata = wr_mask[rb.bus_addr[3:0]] ? mem[rb.bus_addr[3:0]] : init_val(rb.bus_addr[3:0]);
    always @(posedge clk) begin
        if (rb.bus_valid && rb.bus_write) begin
            mem[rb.bus_addr[3:0]]     <= rb.bus_wdata;
            wr_mask[rb.bus_addr[3:0]] <= 1'b1;
        end
    end

    // Requester driver: pop the granted command, then present each queue head
    task automatic run_cycle(input logic [N_REQ-1:0] extra);
        logic [N_REQ-1:0]    rdy;
        logic [N_REQ-1:0]    v, w, l;
        logic [N_REQ*AW-1:0] a;
        logic [N_REQ*DW-1:0] d;
        txn_t                t;
        @(negedge clk);
        rdy = rb.req_ready;
        @(posedge clk);
        #1;
        v = '0; w = '0; l = '0; a = '0; d = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (rdy[i] && cmd_q[i].size() > 0) void'(cmd_q[i].pop_front());
            if (cmd_q[i].size() > 0) begin
                t = cmd_q[i][0];
                v[i] = 1'b1;
                w[i] = t.wr;
                l[i] = t.lk;
                a[i*AW +: AW] = t.addr;
                d[i*DW +: DW] = t.wdata;
            end
        end
        rb.req_valid = v | extra;
        rb.req_write = w;
        rb.req_lock  = l;
        rb.req_addr  = a;
        rb.req_wdata = d;
    endtask

    function automatic bit busy();
        bit b = (grant_q.size() > 0) || (infl_q.size() > 0);
        for (int i = 0; i < N_REQ; i++) b = b || (cmd_q[i].size() > 0);
        return b;
    endfunction

    task automatic drain();
        int n = 0;
        while (busy() && n < 300) begin
            run_cycle('0);
            n++;
        end
        check_eq("drain_timeout", 64'(n < 300), 64'd1);
        repeat (4) run_cycle('0);
    endtask

    // Monitor: grant order, bus contents/timing, responses, rdata hold, reset values
    initial begin
        txn_t          e;
        logic          prev_ready = 1'b0;
        logic          prev_bus   = 1'b0;
        logic [DW-1:0] last_rdata = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                check_eq("reset_outputs", {rb.req_ready, rb.rsp_valid, rb.bus_valid, rb.bus_write,
                         |rb.bus_addr, |rb.bus_wdata, |rb.rsp_rdata}, 64'd0);
                infl_q.delete();
                prev_ready = 1'b0;
                prev_bus   = 1'b0;
                last_rdata = '0;
            end else begin
                check_eq("bus_timing", 64'(rb.bus_valid), 64'(prev_ready));
                check_eq("rsp_timing", 64'(|rb.rsp_valid), 64'(prev_bus));
                if (rb.req_ready != '0) begin
                    check_eq("ready_onehot", 64'($onehot(rb.req_ready)), 64'd1);
                    if (grant_q.size() == 0) begin
                        check_eq("grant_unexpected", 64'(rb.req_ready), 64'd0);
                    end else begin
                        e = grant_q.pop_front();
                        check_eq("grant_idx", 64'(rb.req_ready), 64'd1 << e.idx);
                        infl_q.push_back(e);
                    end
                end
                if (rb.bus_valid) begin
                    if (infl_q.size() == 0) begin
                        check_eq("bus_unexpected", 64'(rb.bus_valid), 64'd0);
                    end else begin
                        e = infl_q[0];
                        check_eq("bus_cmd", {rb.bus_write, rb.bus_addr, rb.bus_wdata},
                                 {e.wr, e.addr, e.wr ? e.wdata : {DW{1'b0}}});
                    end
                end else begin
                    check_eq("bus_idle", {rb.bus_write, rb.bus_addr, rb.bus_wdata}, 64'd0);
                end
                if (rb.rsp_valid != '0) begin
                    check_eq("rsp_onehot", 64'($onehot(rb.rsp_valid)), 64'd1);
                    if (infl_q.size() == 0) begin
                        check_eq("rsp_unexpected", 64'(rb.rsp_valid), 64'd0);
                    end else begin
                        e = infl_q.pop_front();
                        check_eq("rsp_idx", 64'(rb.rsp_valid), 64'd1 << e.idx);
                        check_eq("rsp_rdata", 64'(rb.rsp_rdata), 64'(e.rdata));
                    end
                    last_rdata = rb.rsp_rdata;
                end else begin
                    check_eq("rdata_hold", 64'(rb.rsp_rdata), 64'(last_rdata));
                end
                prev_ready = |rb.req_ready;
                prev_bus   = rb.bus_valid;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst_n        = 1'b0;
        rb.req_valid = '0;
        rb.req_write = '0;
        rb.req_lock  = '0;
        rb.req_addr  = '0;
        rb.req_wdata = '0;
        repeat (3) run_cycle('0);
        rst_n = 1'b1;

        // All three requesting continuously: 0,1,2,0,1,2
        for (int j = 0; j < 2; j++) begin
            for (int i = 0; i < N_REQ; i++) begin
                cmd_q[i].push_back(mk(i, 1'b0, 1'b0, i + 3 * j, '0, init_val(4'(i + 3 * j))));
                grant_q.push_back(mk(i, 1'b0, 1'b0, i + 3 * j, '0, init_val(4'(i + 3 * j))));
            end
        end
        drain();

        // Write then read back through requester 1; write response carries 0
        cmd_q[1].push_back(mk(1, 1'b1, 1'b0, 4, 19'h12345, 19'h00000));
        grant_q.push_back(mk(1, 1'b1, 1'b0, 4, 19'h12345, 19'h00000));
        cmd_q[1].push_back(mk(1, 1'b0, 1'b0, 4, 19'h00000, 19'h12345));
        grant_q.push_back(mk(1, 1'b0, 1'b0, 4, 19'h00000, 19'h12345));
        drain();

        // Single read by requester 2
        cmd_q[2].push_back(mk(2, 1'b0, 1'b0, 4, '0, 19'h12345));
        grant_q.push_back(mk(2, 1'b0, 1'b0, 4, '0, 19'h12345));
        drain();

        // One-cycle valid pulse from requester 1 while requester 0 is in ISSUE
        cmd_q[0].push_back(mk(0, 1'b0, 1'b0, 5, '0, init_val(4'd5)));
        grant_q.push_back(mk(0, 1'b0, 1'b0, 5, '0, init_val(4'd5)));
        run_cycle('0);
        run_cycle(3'b010);
        drain();

        // Reset during ISSUE aborts the read; pending requester 2 wins afterwards
        cmd_q[0].push_back(mk(0, 1'b0, 1'b0, 6, '0, init_val(4'd6)));
        grant_q.push_back(mk(0, 1'b0, 1'b0, 6, '0, init_val(4'd6)));
        run_cycle('0);
        run_cycle('0);
        rst_n = 1'b0;
        cmd_q[2].push_back(mk(2, 1'b0, 1'b0, 7, '0, init_val(4'd7)));
        grant_q.push_back(mk(2, 1'b0, 1'b0, 7, '0, init_val(4'd7)));
        repeat (2) run_cycle('0);
        rst_n = 1'b1;
        drain();

        // Requester 0 holds lock for its first three commands, all three requesting
        for (int k = 0; k < 4; k++) begin
            cmd_q[0].push_back(mk(0, 1'b0, (k < 3) ? 1'b1 : 1'b0, 8 + k, '0, init_val(4'(8 + k))));
        end
        cmd_q[1].push_back(mk(1, 1'b0, 1'b0, 12, '0, init_val(4'd12)));
        cmd_q[2].push_back(mk(2, 1'b0, 1'b0, 13, '0, init_val(4'd13)));
`ifdef REGARB_LOCK_EN
        for (int k = 0; k < 4; k++) begin
            grant_q.push_back(mk(0, 1'b0, (k < 3) ? 1'b1 : 1'b0, 8 + k, '0, init_val(4'(8 + k))));
        end
        grant_q.push_back(mk(1, 1'b0, 1'b0, 12, '0, init_val(4'd12)));
        grant_q.push_back(mk(2, 1'b0, 1'b0, 13, '0, init_val(4'd13)));
`else
        grant_q.push_back(mk(0, 1'b0, 1'b1, 8, '0, init_val(4'd8)));
        grant_q.push_back(mk(1, 1'b0, 1'b0, 12, '0, init_val(4'd12)));
        grant_q.push_back(mk(2, 1'b0, 1'b0, 13, '0, init_val(4'd13)));
        for (int k = 1; k < 4; k++) begin
            grant_q.push_back(mk(0, 1'b0, (k < 3) ? 1'b1 : 1'b0, 8 + k, '0, init_val(4'(8 + k))));
        end
`endif
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
